// File: rtl/hidden_cpu_sequencer.sv
// hidden_cpu_sequencer: runs a stored program on the HiddenCPU pins, one core clock per instruction.
// Optional execution trace when HIDDEN_CPU_SEQ_TRACE_EN is defined.
module hidden_cpu_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [5:0]    load_data,
  input  logic          start,
  input  logic          stop,
  input  logic [7:0]    max_steps,
  output logic [7:0]    cpu_in,
  input  logic [7:0]    cpu_out,
  output logic          busy,
  output logic          halted,
  output logic [1:0]    halt_cause,
  output logic [7:0]    step_count,
  output logic          trace_valid,
  output logic [13:0]   trace_data
);
  typedef enum logic [3:0] {IDLE, RST_SET, RST_CLK, RST_REL, FETCH, SETUP, CLK_HI, SAMPLE, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] pc_q, pc_d, steps_q, steps_d;
  logic [5:0] instr_q, instr_d;
  logic [1:0] cause_q, cause_d;
  logic halted_q, halted_d, stop_q, stop_d;
  logic [5:0] store_q [PROG_DEPTH];
  always_ff @(posedge clk) begin
    if (load_we && !busy) store_q[load_addr] <= load_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      steps_q  <= '0;
      cause_q  <= '0;
      halted_q <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      steps_q  <= steps_d;
      cause_q  <= cause_d;
      halted_q <= halted_d;
      stop_q   <= stop_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    steps_d  = steps_q;
    cause_d  = cause_q;
    halted_d = halted_q;
    cpu_in   = '0;
    busy     = 1'b1;
    case (state_q)
      IDLE, DONE: begin
        busy     = 1'b0;
        state_d  = start ? RST_SET : IDLE;
        halted_d = halted_q && !start;
        cause_d  = start ? 2'd0 : cause_q;
        steps_d  = start ? 8'd0 : steps_q;
      end
      RST_SET: begin
        cpu_in  = 8'h02;
        state_d = RST_CLK;
      end
      RST_CLK: begin
        cpu_in  = 8'h03;
        state_d = RST_REL;
      end
      RST_REL: state_d = FETCH;
      FETCH: begin
        pc_d    = cpu_out;
        instr_d = store_q[cpu_out[AW-1:0]];
        state_d = SETUP;
      end
      SETUP: begin
        cpu_in  = {instr_q, 2'b00};
        state_d = CLK_HI;
      end
      CLK_HI: begin
        cpu_in  = {instr_q, 2'b01};
        steps_d = steps_q + {7'd0, steps_q != 8'hFF};
        state_d = SAMPLE;
      end
      SAMPLE: begin
        cpu_in   = {instr_q, 2'b00};
        // a PC that did not move after an execute edge means the program parked itself
        cause_d  = (stop_q || stop) ? 2'd2 :
                   (max_steps != 8'd0 && steps_q == max_steps) ? 2'd1 :
                   (cpu_out == pc_q) ? 2'd3 : 2'd0;
        halted_d = cause_d != 2'd0;
        state_d  = halted_d ? DONE : FETCH;
      end
      default: state_d = IDLE;
    endcase
    stop_d = busy && state_d != DONE && (stop_q || stop);
  end
  assign halted     = halted_q;
  assign halt_cause = cause_q;
  assign step_count = steps_q;
`ifdef HIDDEN_CPU_SEQ_TRACE_EN
  logic        tv_q;
  logic [13:0] td_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      tv_q <= 1'b0;
      td_q <= '0;
    end else begin
      tv_q <= state_d == CLK_HI;
      if (state_d == CLK_HI) td_q <= {pc_q, instr_q};
    end
  end
  assign trace_valid = tv_q;
  assign trace_data  = td_q;
`else
  assign trace_valid = 1'b0;
  assign trace_data  = '0;
`endif
endmodule

// File: tb/tb_hidden_cpu_sequencer.sv
// tb_hidden_cpu_sequencer: drives random programs through the sequencer against a toy core
// and an instruction-level reference model.
module tb_hidden_cpu_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic load_we = 1'b0, start = 1'b0, stop = 1'b0;
  logic [3:0] load_addr = '0;
  logic [5:0] load_data = '0;
  logic [7:0] max_steps = '0;
  logic [7:0] cpu_in, cpu_out, step_count;
  logic busy, halted, trace_valid;
  logic [1:0] halt_cause;
  logic [13:0] trace_data;
  int n_cmp = 0, n_fail = 0;
  logic [5:0] mem [16];
  logic [13:0] exec_q[$], exp_q[$], tr_q[$];
  int tv_cnt = 0;
  int core_mode = 0;
  logic [7:0] core_pc = 8'd0;

  hidden_cpu_sequencer #(.PROG_DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .start(start), .stop(stop), .max_steps(max_steps), .cpu_in(cpu_in), .cpu_out(cpu_out),
    .busy(busy), .halted(halted), .halt_cause(halt_cause), .step_count(step_count),
    .trace_valid(trace_valid), .trace_data(trace_data)
  );

  always #5 clk = ~clk;

  // Toy core: mode 0 counts up, mode 1 parks, mode 2 jumps by 5*instr[1:0] (parks on 0).
  function automatic logic [7:0] nxt(input logic [7:0] pc, input logic [5:0] ins);
    return core_mode == 0 ? pc + 8'd1 : core_mode == 1 ? pc : pc + 8'd5 * {6'd0, ins[1:0]};
  endfunction

  assign cpu_out = core_pc;
  always @(posedge clk) begin
    if (cpu_in[0]) begin
      if (cpu_in[1]) core_pc <= 8'd0;
      else begin
        exec_q.push_back({core_pc, cpu_in[7:2]});
        core_pc <= nxt(core_pc, cpu_in[7:2]);
      end
    end
  end

  task automatic load_store();
    for (int i = 0; i < 16; i++) begin
      load_we = 1'b1; load_addr = 4'(i); load_data = mem[i];
      @(posedge clk); #1;
    end
    load_we = 1'b0;
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 16; i++) mem[i] = 6'($urandom);
  endtask

  // Instruction-level reference: execute, count, then apply halt rules in priority order.
  task automatic model(input int mx, input int ss, output int es, output int ec);
    logic [7:0] pc, npc;
    logic [5:0] ins;
    pc = 8'd0; es = 0; ec = 0;
    exp_q.delete();
    for (int k = 0; k < 1000 && ec == 0; k++) begin
      ins = mem[pc[3:0]];
      exp_q.push_back({pc, ins});
      npc = nxt(pc, ins);
      if (es < 255) es++;
      if (es == ss) ec = 2;
      else if (mx != 0 && es == mx) ec = 1;
      else if (npc == pc) ec = 3;
      pc = npc;
    end
  endtask

  // Starts a run; stop goes high in SETUP of step stop_step; wr_at: -1 none, 0 with start, k in cycle k.
  task automatic run(input logic [7:0] mx, input int stop_step, input int wr_at, input logic [3:0] waddr,
                     input logic [5:0] wdata, input int budget, output int cyc);
    exec_q.delete(); tr_q.delete(); tv_cnt = 0;
    max_steps = mx;
    start = 1'b1; load_we = (wr_at == 0); load_addr = waddr; load_data = wdata;
    @(posedge clk); #1;
    start = 1'b0; load_we = 1'b0; cyc = 0;
    while (!halted && cyc < budget) begin
      stop = stop_step > 0 && cyc + 1 == 5 + 4 * (stop_step - 1);
      load_we = wr_at > 0 && cyc + 1 == wr_at;
      if (trace_valid) begin tr_q.push_back(trace_data); tv_cnt++; end
      @(posedge clk); #1;
      cyc++;
    end
    stop = 1'b0; load_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (cpu_in !== 8'h00) begin n_fail++; $display("FAIL reset.cpu_in got %h exp 00", cpu_in); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset.busy got %b exp 0", busy); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset.halted got %b exp 0", halted); end
    n_cmp++; if (halt_cause !== 2'd0) begin n_fail++; $display("FAIL reset.cause got %0d exp 0", halt_cause); end
    n_cmp++; if (step_count !== 8'd0) begin n_fail++; $display("FAIL reset.steps got %0d exp 0", step_count); end
    n_cmp++; if (trace_valid !== 1'b0 || trace_data !== 14'd0) begin n_fail++; $display("FAIL reset.trace got %b/%h exp 0/0", trace_valid, trace_data); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_handshake();
    logic [7:0] seq [1:7];
    seq = '{8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    for (int i = 0; i < 16; i++) mem[i] = 6'h00;
    load_store();
    core_mode = 0; max_steps = 8'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL handshake.busy got %b exp 1", busy); end
    for (int c = 1; c <= 7; c++) begin
      if (c != 4) begin
        n_cmp++; if (cpu_in !== seq[c]) begin n_fail++; $display("FAIL handshake.cpu_in[cyc %0d] got %h exp %h", c, cpu_in, seq[c]); end
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (halted !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL handshake.done got halted=%b busy=%b exp 1/0", halted, busy); end
    n_cmp++; if (halt_cause !== 2'd1 || step_count !== 8'd1) begin n_fail++; $display("FAIL handshake.result got cause=%0d steps=%0d exp 1/1", halt_cause, step_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_step_limit();
    int cyc;
    rand_mem(); load_store();
    core_mode = 0;
    run(8'd5, 0, -1, 4'd0, 6'd0, 100, cyc);
    n_cmp++; if (cyc != 23) begin n_fail++; $display("FAIL limit.cycles got %0d exp 23", cyc); end
    n_cmp++; if (halted !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL limit.flags got halted=%b busy=%b exp 1/0", halted, busy); end
    n_cmp++; if (halt_cause !== 2'd1) begin n_fail++; $display("FAIL limit.cause got %0d exp 1", halt_cause); end
    n_cmp++; if (step_count !== 8'd5) begin n_fail++; $display("FAIL limit.steps got %0d exp 5", step_count); end
    n_cmp++; if (exec_q.size() != 5) begin n_fail++; $display("FAIL limit.exec_len got %0d exp 5", exec_q.size()); end
    for (int i = 0; i < 5 && i < exec_q.size(); i++) begin
      n_cmp++; if (exec_q[i] !== {8'(i), mem[i]}) begin n_fail++; $display("FAIL limit.exec[%0d] got %h exp %h", i, exec_q[i], {8'(i), mem[i]}); end
    end
  endtask

  task automatic test_self_loop();
    int cyc;
    rand_mem(); load_store();
    core_mode = 1;
    run(8'd0, 0, -1, 4'd0, 6'd0, 100, cyc);
    n_cmp++; if (halt_cause !== 2'd3) begin n_fail++; $display("FAIL selfloop.cause got %0d exp 3", halt_cause); end
    n_cmp++; if (step_count !== 8'd1) begin n_fail++; $display("FAIL selfloop.steps got %0d exp 1", step_count); end
    n_cmp++; if (cyc != 7) begin n_fail++; $display("FAIL selfloop.cycles got %0d exp 7", cyc); end
  endtask

  task automatic test_stop();
    int cyc;
    rand_mem(); load_store();
    core_mode = 0;
    run(8'd0, 3, -1, 4'd0, 6'd0, 100, cyc);
    n_cmp++; if (halt_cause !== 2'd2) begin n_fail++; $display("FAIL stop.cause got %0d exp 2", halt_cause); end
    n_cmp++; if (step_count !== 8'd3) begin n_fail++; $display("FAIL stop.steps got %0d exp 3", step_count); end
    n_cmp++; if (cyc != 15) begin n_fail++; $display("FAIL stop.cycles got %0d exp 15", cyc); end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (halted !== 1'b1 || halt_cause !== 2'd2 || busy !== 1'b0) begin n_fail++; $display("FAIL stop.idle got halted=%b cause=%0d busy=%b exp 1/2/0", halted, halt_cause, busy); end
    run(8'd2, 0, -1, 4'd0, 6'd0, 100, cyc);
    n_cmp++; if (halt_cause !== 2'd1 || step_count !== 8'd2) begin n_fail++; $display("FAIL stop.after_idle got cause=%0d steps=%0d exp 1/2", halt_cause, step_count); end
  endtask

  task automatic test_loader();
    int cyc;
    logic [5:0] nv;
    rand_mem();
    mem[2] = 6'h15;
    load_store();
    core_mode = 0;
    run(8'd6, 0, 3, 4'd2, 6'h3F, 100, cyc);
    n_cmp++; if (halt_cause !== 2'd1 || step_count !== 8'd6) begin n_fail++; $display("FAIL loader.busy_run got cause=%0d steps=%0d exp 1/6", halt_cause, step_count); end
    run(8'd4, 0, -1, 4'd0, 6'd0, 100, cyc);
    n_cmp++; if (exec_q.size() < 3 || exec_q[2] !== {8'd2, mem[2]}) begin n_fail++; $display("FAIL loader.store2 got %h exp %h", exec_q.size() < 3 ? 14'h0 : exec_q[2], {8'd2, mem[2]}); end
`ifdef HIDDEN_CPU_SEQ_TRACE_EN
    n_cmp++; if (tr_q.size() != 4) begin n_fail++; $display("FAIL loader.trace_len got %0d exp 4", tr_q.size()); end
    n_cmp++; if (tr_q.size() < 1 || tr_q[0] !== {8'h00, mem[0]}) begin n_fail++; $display("FAIL loader.trace0 got %h exp %h", tr_q.size() < 1 ? 14'h0 : tr_q[0], {8'h00, mem[0]}); end
`else
    n_cmp++; if (tv_cnt != 0) begin n_fail++; $display("FAIL loader.trace_valid got %0d pulses exp 0", tv_cnt); end
    n_cmp++; if (trace_data !== 14'd0) begin n_fail++; $display("FAIL loader.trace_data got %h exp 0", trace_data); end
`endif
    nv = mem[0] ^ 6'h2A;
    mem[0] = nv;
    run(8'd1, 0, 0, 4'd0, nv, 50, cyc);
    n_cmp++; if (exec_q.size() < 1 || exec_q[0] !== {8'h00, nv}) begin n_fail++; $display("FAIL loader.write_with_start got %h exp %h", exec_q.size() < 1 ? 14'h0 : exec_q[0], {8'h00, nv}); end
  endtask

  task automatic test_reset_midrun();
    rand_mem(); load_store();
    core_mode = 0; max_steps = 8'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    n_cmp++; if (cpu_in[1:0] !== 2'b01 || step_count !== 8'd1) begin n_fail++; $display("FAIL midrst.pre got pins=%b steps=%0d exp 01/1", cpu_in[1:0], step_count); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0 || cpu_in !== 8'h00) begin n_fail++; $display("FAIL midrst.idle got busy=%b cpu_in=%h exp 0/00", busy, cpu_in); end
    n_cmp++; if (step_count !== 8'd0 || halted !== 1'b0 || halt_cause !== 2'd0) begin n_fail++; $display("FAIL midrst.regs got steps=%0d halted=%b cause=%0d exp 0/0/0", step_count, halted, halt_cause); end
    n_cmp++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL midrst.trace_valid got %b exp 0", trace_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    int cyc;
    rand_mem(); load_store();
    core_mode = 0;
    run(8'd0, 260, -1, 4'd0, 6'd0, 1200, cyc);
    n_cmp++; if (step_count !== 8'd255) begin n_fail++; $display("FAIL saturate.steps got %0d exp 255", step_count); end
    n_cmp++; if (halt_cause !== 2'd2 || cyc != 1043) begin n_fail++; $display("FAIL saturate.end got cause=%0d cycles=%0d exp 2/1043", halt_cause, cyc); end
  endtask

  task automatic test_random();
    int cyc, mx, ss, es, ec;
    for (int r = 0; r < 20; r++) begin
      rand_mem(); load_store();
      core_mode = $urandom_range(0, 2);
      mx = $urandom_range(1, 30);
      ss = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
      model(mx, ss, es, ec);
      run(8'(mx), ss, -1, 4'd0, 6'd0, 200, cyc);
      n_cmp++; if (halted !== 1'b1 || busy !== 1'b0 || halt_cause !== 2'(ec)) begin n_fail++; $display("FAIL rand%0d.end got halted=%b busy=%b cause=%0d exp 1/0/%0d", r, halted, busy, halt_cause, ec); end
      n_cmp++; if (step_count !== 8'(es)) begin n_fail++; $display("FAIL rand%0d.steps got %0d exp %0d", r, step_count, es); end
      n_cmp++; if (cyc != 3 + 4 * exp_q.size()) begin n_fail++; $display("FAIL rand%0d.cycles got %0d exp %0d", r, cyc, 3 + 4 * exp_q.size()); end
      n_cmp++; if (exec_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d.exec_len got %0d exp %0d", r, exec_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < exec_q.size(); i++) begin
        n_cmp++; if (exec_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d.exec[%0d] got %h exp %h", r, i, exec_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_handshake();
    test_step_limit();
    test_self_loop();
    test_stop();
    test_loader();
    test_reset_midrun();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/hidden_cpu_sequencer.md
# hidden_cpu_sequencer

Program sequencer that drives the 8-bit pin interface of the HiddenCPU core (in[0]=clk, in[1]=rst, in[7:2]=instruction {opcode, rA, rB}) from an on-chip instruction store. Host loads a program, pulses `start`. The block resets the core, then repeatedly fetches the instruction addressed by the core's output byte (PC), presents it, and generates one core clock pulse per instruction. Execution stops on a step limit, a host stop, or a PC self-loop. Sits between the host/test harness and the core pins.

## Interface
- `PROG_DEPTH`, 16: instruction store entries; power of two, 2..64.
- `AW`, 4: store address width, equal to log2(PROG_DEPTH).
- `clk  in  1  system clock`
- `rst  in  1  synchronous, active-high reset`
- `load_we  in  1  write load_data into store[load_addr]; accepted only when busy=0`
- `load_addr  in  AW  store write address`
- `load_data  in  6  instruction {opcode[1:0], rA[1:0], rB[1:0]}`
- `start  in  1  one-cycle pulse; begins a run when busy=0`
- `stop  in  1  one-cycle pulse; requests halt`
- `max_steps  in  8  step limit; 0 means unlimited`
- `cpu_in  out  8  core pin drive: [7:2] instruction, [1] core rst, [0] core clk`
- `cpu_out  in  8  core output byte, read as PC`
- `busy  out  1  run in progress`
- `halted  out  1  sticky done flag; cleared by start`
- `halt_cause  out  2  0=none, 1=step limit, 2=stop, 3=self-loop`
- `step_count  out  8  instructions executed this run, saturating at 255`
- `trace_valid  out  1  one-cycle strobe per executed instruction (SEQ_TRACE_EN only)`
- `trace_data  out  14  {PC before step, instruction} (SEQ_TRACE_EN only)`

## Operation
- States: IDLE, RST_SET, RST_CLK, RST_REL, FETCH, SETUP, CLK_HI, SAMPLE, DONE.
- IDLE: cpu_in=0. `load_we` writes the store. `start` clears halted, halt_cause and step_count, sets busy, and moves to RST_SET.
- RST_SET: cpu_in=8'h02. RST_CLK: cpu_in=8'h03, which is the core reset edge. RST_REL: cpu_in=8'h00, then FETCH.
- FETCH: latch pc_q = cpu_out; read instr = store[cpu_out[AW-1:0]] (upper PC bits ignored, wrap modulo PROG_DEPTH).
- SETUP: cpu_in = {instr,2'b00}. CLK_HI: cpu_in = {instr,2'b01}, which is the core execute edge; step_count increments (saturating).
- SAMPLE: cpu_in = {instr,2'b00}. Halt checks run in priority order:
  - stop pending → cause 2.
  - `max_steps`≠0 and step_count==max_steps → cause 1.
  - cpu_out==pc_q → cause 3.
  - Otherwise go to FETCH.
- DONE: busy=0, halted=1, cpu_in=0, then IDLE.
- `stop` is latched when it arrives in any busy state and is cleared on entering DONE. `stop` while idle is ignored.
- `start` while busy is ignored. `load_we` while busy is ignored; the store is unchanged.
- `load_we` and `start` in the same idle cycle: the write completes first, and the run sees the new data.
- `rst` in any state: return to IDLE next cycle; all outputs at reset values. Store contents are unaffected; they have no reset.

## Timing
- Reset values: cpu_in=0, busy=0, halted=0, halt_cause=0, step_count=0, trace_valid=0, trace_data=0.
- busy rises the cycle after `start`.
- The core reset sequence takes 3 cycles.
- Each instruction takes 4 cycles (FETCH, SETUP, CLK_HI, SAMPLE). The core clk is high for exactly 1 cycle, and instruction bits are stable 1 cycle before and 1 cycle after the core clk edge.
- Halt checks use cpu_out as sampled in SAMPLE.
- halted rises 1 cycle after the SAMPLE that triggers the halt.
- An unlimited run with no stop and no self-loop continues indefinitely; step_count holds at 255.

## Configuration
- `HIDDEN_CPU_SEQ_TRACE_EN` defined: trace_valid pulses in CLK_HI with trace_data = {pc_q, instr}.
- Not defined: the trace ports are still present but tied to 0, and no trace registers are built.

## Test plan
- Reset: assert rst mid-run (in CLK_HI) → next cycle busy=0, cpu_in=0, step_count=0.
- Reset handshake: load store all 6'h00, start → cpu_in sequence 02, 03, 00, then {00,0}, {00,1}, {00,0}; busy=1 from cycle 1.
- Step limit: max_steps=5 with core PC advancing by 1 → after 5 steps halted=1, cause=1, step_count=5, busy=0.
- Self-loop: model the core returning the same PC after one step → halt cause=3, step_count=1.
- Stop: pulse stop during SETUP of step 3 → step 3 completes, halt cause=2, step_count=3. A stop pulse while idle has no effect.
- Loader: load_we while busy (addr 2, data 6'h3F) is ignored → a later run fetches the original store[2]. Trace (macro on): trace_data of step 1 = {8'h00, store[0]}.
